// File: rtl/seg_scan_ctrl_pkg.sv
// seg_pkg: shared constants and types for the seven-segment scan controller.
//   NUM_DIGITS   - number of multiplexed digits on the display
//   slot_state_e - per-slot state: BLANK (anti-ghosting guard) or DRIVE
//   GLYPH_TABLE  - hex nibble -> segment pattern {g,f,e,d,c,b,a}, bit0 = a
package seg_pkg;

  localparam int NUM_DIGITS = 4;

  typedef enum logic {
    SLOT_BLANK = 1'b0,
    SLOT_DRIVE = 1'b1
  } slot_state_e;

  // Listed from nibble F down to nibble 0 so that GLYPH_TABLE[n] is the glyph of n.
  localparam logic [15:0][6:0] GLYPH_TABLE = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h67, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// seg_scan_ctrl_if: load bus and display pins of the scan controller.
//   value[15:0] - four hex nibbles, digit0 = value[3:0]
//   load        - single-cycle strobe, samples value and dp
//   dp[3:0]     - decimal-point request per digit
//   an[3:0]     - digit anodes, active-low
//   seg[6:0]    - segments {g,f,e,d,c,b,a}, active-high
//   seg_dp      - decimal point, active-high
//   frame_done  - one-cycle pulse at the end of the digit 3 slot
// master drives the load side, slave is the controller.
interface seg_scan_ctrl_if;
  logic [15:0] value;
  logic        load;
  logic [3:0]  dp;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        seg_dp;
  logic        frame_done;

  modport master (
    output value, load, dp,
    input  an, seg, seg_dp, frame_done
  );

  modport slave (
    input  value, load, dp,
    output an, seg, seg_dp, frame_done
  );
endinterface

// File: rtl/seg_scan_ctrl_hex7_decode.sv
// hex7_decode: combinational hex nibble to seven-segment glyph lookup.
//   nibble[3:0] - hex digit
//   glyph[6:0]  - segments {g,f,e,d,c,b,a}, active-high
module hex7_decode
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] glyph
);

  assign glyph = GLYPH_TABLE[nibble];

endmodule

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: four-digit multiplexed seven-segment scan controller with
// frame-synchronous double buffering of the displayed value.
//   Parameters: CLK_DIV (cycles per digit slot, 4..2^20),
//               GUARD   (blanking cycles at slot start, 1..CLK_DIV-2)
//   clk - system clock, rising edge
//   rst - asynchronous active-high reset
//   bus - seg_scan_ctrl_if.slave: value/load/dp in, an/seg/seg_dp/frame_done out
// Optional build macro LEADING_ZERO_BLANK_EN: suppress leading zero digits
// (never digit 0, never a digit with its decimal point requested).
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int CLK_DIV = 50000,
  parameter int GUARD   = 64
) (
  input  logic            clk,
  input  logic            rst,
  seg_scan_ctrl_if.slave  bus
);

  localparam int         CNT_W      = $clog2(CLK_DIV);
  localparam logic [1:0] LAST_DIGIT = 2'(NUM_DIGITS - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       idx_q, idx_d;
  slot_state_e      state_q, state_d;
  logic [15:0]      shadow_q, shadow_d;
  logic [3:0]       shadow_dp_q, shadow_dp_d;
  logic [15:0]      pending_q, pending_d;
  logic [3:0]       pending_dp_q, pending_dp_d;
  logic             pend_valid_q, pend_valid_d;
  logic [3:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;
  logic             seg_dp_q, seg_dp_d;
  logic             frame_done_q, frame_done_d;

  logic             tick;
  logic             frame_tick;
  logic [3:0]       nibble;
  logic [6:0]       glyph;
  logic             digit_blank;

  hex7_decode u_hex7_decode (
    .nibble (nibble),
    .glyph  (glyph)
  );

  // Prescaler, digit index, slot state and the pending/shadow double buffer.
  // The shadow only changes on the frame tick, so a frame never mixes values.
  always_comb begin
    tick       = (cnt_q == CNT_W'(CLK_DIV - 1));
    frame_tick = tick && (idx_q == LAST_DIGIT);

    cnt_d   = tick ? '0 : cnt_q + CNT_W'(1);
    idx_d   = tick ? idx_q + 2'd1 : idx_q;
    state_d = (cnt_d < CNT_W'(GUARD)) ? SLOT_BLANK : SLOT_DRIVE;

    shadow_d     = shadow_q;
    shadow_dp_d  = shadow_dp_q;
    pending_d    = pending_q;
    pending_dp_d = pending_dp_q;
    pend_valid_d = pend_valid_q;

    if (bus.load && frame_tick) begin
      // A load landing on the frame boundary bypasses the pending stage.
      shadow_d     = bus.value;
      shadow_dp_d  = bus.dp;
      pending_d    = bus.value;
      pending_dp_d = bus.dp;
      pend_valid_d = 1'b0;
    end else if (bus.load) begin
      pending_d    = bus.value;
      pending_dp_d = bus.dp;
      pend_valid_d = 1'b1;
    end else if (frame_tick && pend_valid_q) begin
      shadow_d     = pending_q;
      shadow_dp_d  = pending_dp_q;
      pend_valid_d = 1'b0;
    end
  end

  // Select the nibble of the current digit and decide leading-zero blanking.
  always_comb begin
    case (idx_q)
      2'd0:    nibble = shadow_q[3:0];
      2'd1:    nibble = shadow_q[7:4];
      2'd2:    nibble = shadow_q[11:8];
      default: nibble = shadow_q[15:12];
    endcase

`ifdef LEADING_ZERO_BLANK_EN
    case (idx_q)
      2'd0:    digit_blank = 1'b0;
      2'd1:    digit_blank = (shadow_q[15:4]  == 12'h000) && !shadow_dp_q[1];
      2'd2:    digit_blank = (shadow_q[15:8]  == 8'h00)   && !shadow_dp_q[2];
      default: digit_blank = (shadow_q[15:12] == 4'h0)    && !shadow_dp_q[3];
    endcase
`else
    digit_blank = 1'b0;
`endif
  end

  // Output pins are computed from the current slot state and registered.
  always_comb begin
    an_d         = 4'b1111;
    seg_d        = 7'b0000000;
    seg_dp_d     = 1'b0;
    frame_done_d = frame_tick;

    if (state_q == SLOT_DRIVE && !digit_blank) begin
      an_d[idx_q] = 1'b0;
      seg_d       = glyph;
      seg_dp_d    = shadow_dp_q[idx_q];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q        <= '0;
      idx_q        <= 2'd0;
      state_q      <= SLOT_BLANK;
      shadow_q     <= 16'h0000;
      shadow_dp_q  <= 4'b0000;
      pending_q    <= 16'h0000;
      pending_dp_q <= 4'b0000;
      pend_valid_q <= 1'b0;
      an_q         <= 4'b1111;
      seg_q        <= 7'b0000000;
      seg_dp_q     <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      state_q      <= state_d;
      shadow_q     <= shadow_d;
      shadow_dp_q  <= shadow_dp_d;
      pending_q    <= pending_d;
      pending_dp_q <= pending_dp_d;
      pend_valid_q <= pend_valid_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      seg_dp_q     <= seg_dp_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign bus.an         = an_q;
  assign bus.seg        = seg_q;
  assign bus.seg_dp     = seg_dp_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: self-checking bench for seg_scan_ctrl with CLK_DIV=8, GUARD=2.
// A cycle-count based display model is compared against the DUT on every
// falling edge; directed literal checks pin the model at chosen cycles.
module tb_seg_scan_ctrl;

  localparam int CLK_DIV = 8;
  localparam int GUARD   = 2;
  localparam int FRAME   = 4 * CLK_DIV;

  logic clk = 1'b0;
  logic rst = 1'b0;

  seg_scan_ctrl_if bus_if ();

  seg_scan_ctrl #(
    .CLK_DIV (CLK_DIV),
    .GUARD   (GUARD)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [6:0] glyph_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h67, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  // Model state: mk counts clock edges since reset release.
  int          mk = 0;
  logic [15:0] m_shadow, m_pend;
  logic [3:0]  m_sdp, m_pdp;
  logic        m_pv;
  logic [11:0] exp_out = 12'hF00;
  logic        exp_fd  = 1'b0;

  // What the display must show while the cycle-m state is current.
  function automatic logic [11:0] model_out(int m, logic [15:0] sh, logic [3:0] sd);
    int         pos;
    int         dig;
    logic [3:0] a;
    logic [6:0] s;
    logic       d;
    logic [3:0] nib;
    bit         blank;
    pos   = m % CLK_DIV;
    dig   = (m / CLK_DIV) % 4;
    a     = 4'hF;
    s     = 7'h00;
    d     = 1'b0;
    blank = 1'b0;
    if (pos >= GUARD) begin
      nib = 4'(sh >> (4 * dig));
`ifdef LEADING_ZERO_BLANK_EN
      if (dig > 0 && (sh >> (4 * dig)) == 16'h0 && !sd[dig]) blank = 1'b1;
`endif
      if (!blank) begin
        a[dig] = 1'b0;
        s      = glyph_tab[nib];
        d      = sd[dig];
      end
    end
    return {a, s, d};
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mk       <= 0;
      m_shadow <= 16'h0;
      m_sdp    <= 4'h0;
      m_pend   <= 16'h0;
      m_pdp    <= 4'h0;
      m_pv     <= 1'b0;
      exp_out  <= 12'hF00;
      exp_fd   <= 1'b0;
    end else begin
      mk      <= mk + 1;
      exp_out <= model_out(mk, m_shadow, m_sdp);
      exp_fd  <= (mk % FRAME == FRAME - 1);
      if (bus_if.load && (mk % FRAME == FRAME - 1)) begin
        m_shadow <= bus_if.value;
        m_sdp    <= bus_if.dp;
        m_pv     <= 1'b0;
      end else if (bus_if.load) begin
        m_pend <= bus_if.value;
        m_pdp  <= bus_if.dp;
        m_pv   <= 1'b1;
      end else if ((mk % FRAME == FRAME - 1) && m_pv) begin
        m_shadow <= m_pend;
        m_sdp    <= m_pdp;
        m_pv     <= 1'b0;
      end
    end
  end

  task automatic checkOutput(string name, logic [31:0] act, logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s: got %h required %h at %0t", name, act, req, $time);
    end
  endtask

  // Continuous comparison against the model.
  always @(negedge clk) begin
    checkOutput("model an/seg/dp", {20'h0, bus_if.an, bus_if.seg, bus_if.seg_dp}, {20'h0, exp_out});
    checkOutput("model frame_done", {31'h0, bus_if.frame_done}, {31'h0, exp_fd});
  end

  task automatic stepTo(int k);
    int guard_cnt = 0;
    while (mk < k && guard_cnt < 1000) begin
      @(negedge clk);
      guard_cnt++;
    end
    if (mk != k) begin
      total++;
      bad++;
      $display("[TB] FAIL stepTo: cycle %0d required %0d", mk, k);
    end
  endtask

  task automatic applyStimulus(logic [15:0] v, logic [3:0] d);
    bus_if.value = v;
    bus_if.dp    = d;
    bus_if.load  = 1'b1;
    @(negedge clk);
    bus_if.load  = 1'b0;
  endtask

  task automatic checkPins(string name, logic [3:0] a, logic [6:0] s, logic d);
    checkOutput(name, {20'h0, bus_if.an, bus_if.seg, bus_if.seg_dp}, {20'h0, a, s, d});
  endtask

  initial begin
    bus_if.value = 16'h0;
    bus_if.dp    = 4'h0;
    bus_if.load  = 1'b0;
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    checkPins("reset pins", 4'hF, 7'h00, 1'b0);
    checkOutput("reset frame_done", {31'h0, bus_if.frame_done}, 32'h0);
    rst = 1'b0;

    stepTo(1);   checkPins("digit0 blank", 4'hF, 7'h00, 1'b0);
    stepTo(3);   checkPins("digit0 drive", 4'hE, 7'h3F, 1'b0);
    stepTo(11);  checkPins("digit1 drive", 4'hD, 7'h3F, 1'b0);
    stepTo(32);  checkOutput("frame_done pulse", {31'h0, bus_if.frame_done}, 32'h1);
    stepTo(33);  checkOutput("frame_done end", {31'h0, bus_if.frame_done}, 32'h0);

    stepTo(40);  applyStimulus(16'h1A2F, 4'b0100);
    stepTo(51);  checkPins("no tearing", 4'hB, 7'h3F, 1'b0);
    stepTo(68);  checkPins("1A2F digit0", 4'hE, 7'h71, 1'b0);
    stepTo(76);  checkPins("1A2F digit1", 4'hD, 7'h5B, 1'b0);
    stepTo(84);  checkPins("1A2F digit2", 4'hB, 7'h77, 1'b1);
    stepTo(92);  checkPins("1A2F digit3", 4'h7, 7'h06, 1'b0);

    stepTo(100); applyStimulus(16'h1111, 4'h0);
    stepTo(104); applyStimulus(16'h2222, 4'h0);
    stepTo(132); checkPins("overwrite digit0", 4'hE, 7'h5B, 1'b0);
    stepTo(150); applyStimulus(16'h1111, 4'h0);
    stepTo(156); checkPins("overwrite digit3", 4'h7, 7'h5B, 1'b0);
    stepTo(159); applyStimulus(16'h0042, 4'h0);
    stepTo(164); checkPins("tick load digit0", 4'hE, 7'h5B, 1'b0);
    stepTo(172); checkPins("tick load digit1", 4'hD, 7'h66, 1'b0);

    stepTo(195); applyStimulus(16'h9999, 4'h0);
    checkPins("no stale pending", 4'hE, 7'h5B, 1'b0);
    stepTo(213);
`ifdef LEADING_ZERO_BLANK_EN
    checkPins("pre-reset digit2", 4'hF, 7'h00, 1'b0);
`else
    checkPins("pre-reset digit2", 4'hB, 7'h3F, 1'b0);
`endif
    #2 rst = 1'b1;
    #1 checkPins("async reset", 4'hF, 7'h00, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    stepTo(3);   checkPins("post-reset digit0", 4'hE, 7'h3F, 1'b0);
    stepTo(35);  checkPins("pending discarded", 4'hE, 7'h3F, 1'b0);
    stepTo(44);  checkPins("pending discarded d1", 4'hD, 7'h3F, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
